// File: rtl/alu_pkg.sv
// Package shared by the sequential ALU execution stage.
// Holds the 3-bit ALUControl encodings, the FSM state encoding and a small
// decode helper used by both the top and the combinational core.
package alu_pkg;

  // ALUControl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  // FSM state encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StExec  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;

  function automatic logic is_shift(input logic [2:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: add, sub, and, or, slt on latched operands.
// Shift codes produce zero here; shifts are handled iteratively by the top.
// Optional macro ALU_FLAGS_EN adds carry and signed-overflow outputs.
// Ports:
//   ctrl_i      ALUControl code
//   a_i, b_i    operands
//   y_o         result
//   carry_o     carry-out (add) / A>=B unsigned (sub), 0 otherwise  [ALU_FLAGS_EN]
//   overflow_o  signed overflow for add/sub, 0 otherwise            [ALU_FLAGS_EN]
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       ctrl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry_o,
  output logic             overflow_o
`endif
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             slt;

  // add uses A+B; sub and slt share the A+~B+1 path
  assign sub   = (ctrl_i != ALU_ADD);
  assign b_eff = sub ? ~b_i : b_i;
  assign {cout, sum} = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

  // Signs differ: A<B iff A negative. Same sign: unsigned borrow decides.
  assign slt = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) ? a_i[WIDTH-1] : ~cout;

  always_comb begin
    y_o = '0;
    case (ctrl_i)
      ALU_ADD, ALU_SUB: y_o = sum;
      ALU_AND:          y_o = a_i & b_i;
      ALU_OR:           y_o = a_i | b_i;
      ALU_SLT:          y_o = {{(WIDTH-1){1'b0}}, slt};
      default:          y_o = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic arith;
  assign arith      = (ctrl_i == ALU_ADD) || (ctrl_i == ALU_SUB);
  assign carry_o    = arith & cout;
  assign overflow_o = arith & (a_i[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a_i[WIDTH-1]);
`endif

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU execution stage. Logic/arith ops complete one cycle after
// accept; shifts run one bit per cycle under a start/busy/done handshake.
// Optional macro ALU_FLAGS_EN adds registered Zero/Negative/Carry/Overflow.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request, sampled only in IDLE
//   ALUControl        operation code (see alu_pkg)
//   SrcA, SrcB        operands; SrcB[SHW-1:0] is the shift amount
//   busy              high while not IDLE
//   done              one-cycle pulse, ALUResult (and flags) valid
//   ALUResult         registered result, held until next done
//   Zero..Overflow    result flags                                [ALU_FLAGS_EN]
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult
`ifdef ALU_FLAGS_EN
  ,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
`endif
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] a_q, a_d;     // operand A, doubles as the shift register
  logic [WIDTH-1:0] b_q, b_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] comb_y;
  logic [WIDTH-1:0] shifted;
  logic             fin;
  logic [WIDTH-1:0] fin_val;

`ifdef ALU_FLAGS_EN
  logic comb_carry, comb_ovf;
  logic [3:0] flags_q, flags_d;   // {Zero, Negative, Carry, Overflow}
`endif

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_alu_comb (
    .ctrl_i    (ctrl_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .y_o       (comb_y)
`ifdef ALU_FLAGS_EN
    ,
    .carry_o   (comb_carry),
    .overflow_o(comb_ovf)
`endif
  );

  // One-bit shift step for the latched shift op
  always_comb begin
    shifted = {a_q[WIDTH-2:0], 1'b0};
    case (ctrl_q)
      ALU_SRL: shifted = {1'b0, a_q[WIDTH-1:1]};
      ALU_SRA: shifted = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      default: shifted = {a_q[WIDTH-2:0], 1'b0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = 1'b0;
    fin     = 1'b0;
    fin_val = a_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          ctrl_d  = ALUControl;
          a_d     = SrcA;
          b_d     = SrcB;
          cnt_d   = SrcB[SHW-1:0];
          // Zero-distance shifts take the single-cycle path and return SrcA
          if (is_shift(ALUControl) && (SrcB[SHW-1:0] != '0)) state_d = StShift;
          else                                               state_d = StExec;
        end
      end
      StExec: begin
        fin     = 1'b1;
        fin_val = is_shift(ctrl_q) ? a_q : comb_y;
        state_d = StIdle;
      end
      StShift: begin
        if (cnt_q == '0) begin
          fin     = 1'b1;
          fin_val = a_q;
          state_d = StIdle;
        end else begin
          a_d   = shifted;
          cnt_d = cnt_q - SHW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (fin) begin
      res_d  = fin_val;
      done_d = 1'b1;
    end
  end

`ifdef ALU_FLAGS_EN
  // comb_carry/comb_ovf are already zero for non-add/sub codes
  always_comb begin
    flags_d = flags_q;
    if (fin) flags_d = {(fin_val == '0), fin_val[WIDTH-1], comb_carry, comb_ovf};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
`ifdef ALU_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
`ifdef ALU_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign ALUResult = res_q;
`ifdef ALU_FLAGS_EN
  assign {Zero, Negative, Carry, Overflow} = flags_q;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: the driver pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA, SrcB;
  logic        busy, done;
  logic [31:0] ALUResult;
`ifdef ALU_FLAGS_EN
  logic Zero, Negative, Carry, Overflow;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;     // {Z, N, C, V}
    logic        chk_flags;
    logic [7:0]  id;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ALUControl(ALUControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .busy      (busy),
    .done      (done),
    .ALUResult (ALUResult)
`ifdef ALU_FLAGS_EN
    ,
    .Zero      (Zero),
    .Negative  (Negative),
    .Carry     (Carry),
    .Overflow  (Overflow)
`endif
  );

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done result=%h", ALUResult);
      end else begin
        mon_e = sb_q.pop_front();
        if (ALUResult !== mon_e.res) begin
          failures++;
          $display("FAIL result id=%0d got=%h want=%h", mon_e.id, ALUResult, mon_e.res);
        end
`ifdef ALU_FLAGS_EN
        if (mon_e.chk_flags) begin
          checks++;
          if ({Zero, Negative, Carry, Overflow} !== mon_e.flags) begin
            failures++;
            $display("FAIL flags id=%0d got=%b want=%b", mon_e.id,
                     {Zero, Negative, Carry, Overflow}, mon_e.flags);
          end
        end
`endif
      end
    end
  end

  // Issue one op starting at a negedge; return at the negedge where done is seen.
  // hold_start keeps start high with junk inputs while busy.
  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat,
                        input logic [3:0] exp_flags, input logic chk_f,
                        input logic hold_start, input logic [7:0] id);
    int lat;
    int busy_cnt;
    bit seen;
    sb_q.push_back('{res: exp_res, flags: exp_flags, chk_flags: chk_f, id: id});
    ALUControl = c;
    SrcA       = a;
    SrcB       = b;
    start      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) begin
      start = 1'b0;
    end else begin
      ALUControl = 3'b000;
      SrcA       = 32'hDEAD_BEEF;
      SrcB       = 32'h0000_0001;
    end
    lat = 0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int j = 1; j <= 64 && !seen; j++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = j - 1;
      end else if (busy) begin
        busy_cnt++;
      end
    end
    start = 1'b0;
    checks++;
    if (!seen || lat != exp_lat) begin
      failures++;
      $display("FAIL latency id=%0d got=%0d seen=%0d want=%0d", id, lat, seen, exp_lat);
    end
    checks++;
    if (busy_cnt != exp_lat) begin
      failures++;
      $display("FAIL busy_cycles id=%0d got=%0d want=%0d", id, busy_cnt, exp_lat);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ALUResult !== 32'h0) begin
      failures++;
      $display("FAIL %s busy=%b done=%b result=%h want busy=0 done=0 result=0",
               tag, busy, done, ALUResult);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if ({Zero, Negative, Carry, Overflow} !== 4'b0000) begin
      failures++;
      $display("FAIL %s_flags got=%b want=0000", tag, {Zero, Negative, Carry, Overflow});
    end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    ALUControl = 3'b000;
    SrcA       = '0;
    SrcB       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    //     ctrl    A             B             expected      lat flags  chkf hold id
    run_op(3'b000, 32'd7,        32'd5,        32'd12,        1, 4'b0000, 0, 0, 1);
    run_op(3'b001, 32'd3,        32'hFFFFFFFF, 32'd4,         1, 4'b0000, 0, 0, 2);
    run_op(3'b101, 32'd3,        32'hFFFFFFFF, 32'd0,         1, 4'b0000, 0, 0, 3);
    run_op(3'b101, 32'hFFFFFFFF, 32'd3,        32'd1,         1, 4'b0000, 0, 0, 4);
    run_op(3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000,  1, 4'b0000, 0, 0, 5);
    run_op(3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0,  1, 4'b0000, 0, 0, 6);
    run_op(3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,         1, 4'b0000, 0, 0, 7);
    run_op(3'b111, 32'h80000000, 32'd4,        32'hF8000000,  5, 4'b0000, 0, 0, 8);
    run_op(3'b100, 32'h12345678, 32'd0,        32'h12345678,  1, 4'b0000, 0, 0, 9);
    run_op(3'b110, 32'hF0000000, 32'h25,       32'h07800000,  6, 4'b0000, 0, 0, 10);
    run_op(3'b000, 32'h7FFFFFFF, 32'd1,        32'h80000000,  1, 4'b0101, 1, 0, 11);
    run_op(3'b001, 32'd5,        32'd5,        32'd0,         1, 4'b1010, 1, 0, 12);
    // start held high (with changing inputs) for the whole shift
    run_op(3'b100, 32'h00000AB1, 32'd8,        32'h000AB100,  9, 4'b0000, 0, 1, 13);
    repeat (4) @(negedge clk);

    // Reset during a 10-step shift: no done, everything back to reset values
    ALUControl = 3'b100;
    SrcA       = 32'd1;
    SrcB       = 32'd10;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("reset_mid_shift");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
